instruction_fetch: RTL

- Upstream front end for the decode stage.
- Holds the PC and fetches 32-bit instructions over a grant/response instruction-memory interface with one request outstanding.
- Presents each instruction with its PC and opcode field to decode over a valid/ready handshake.
- if_opcode drives the control unit's opcode input directly.
- A redirect input (branch/jump) flushes and restarts fetch.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, fixed encodings and
// the default reset PC.
package riscv_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [INSTR_W-1:0]  NOP_INSTR        = 32'h0000_0013;
    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE     = 7'b0110011;
    localparam logic [31:0]         DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH: may request; WAIT: granted, awaiting response;
    // DROP: granted request is stale, its response is discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, fetches one 32-bit word at a time
// over a grant/response memory port (one request outstanding) and hands each
// instruction with its PC to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/addr/gnt     request side of instruction memory (req combinational)
//   imem_rvalid/rdata     single-cycle response pulse and instruction word
//   redirect_valid/pc     branch/jump redirect, flushes and restarts fetch
//   if_valid/ready        output handshake towards decode
//   if_pc/instr/opcode    instruction payload (opcode = instr[6:0])
//   perf_fetched/stall    performance counters, only with FETCH_PERF_EN defined
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall,
`endif
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_opcode
);

    fetch_state_t       state, state_n;
    logic [XLEN-1:0]    pc, pc_n;
    logic               out_valid, out_valid_n;
    logic [XLEN-1:0]    out_pc_n;
    logic [INSTR_W-1:0] out_instr_n;
    logic               req;
    logic               capture;
    logic [XLEN-1:0]    redirect_aligned;

    // Low target bits are dropped: misaligned redirects truncate silently.
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // State, PC and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            if_pc     <= '0;
            if_instr  <= NOP_INSTR;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_valid <= out_valid_n;
            if_pc     <= out_pc_n;
            if_instr  <= out_instr_n;
        end
    end

    // Next-state, request and capture logic; redirect overrides everything.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        out_valid_n = out_valid;
        out_pc_n    = if_pc;
        out_instr_n = if_instr;
        req         = 1'b0;
        capture     = 1'b0;

        case (state)
            FETCH: begin
                // Only request with a free output slot: responses cannot stall.
                req = !out_valid || if_ready;
                if (req && imem_gnt) state_n = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_n = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase

        if (capture) begin
            out_valid_n = 1'b1;
            out_pc_n    = pc;
            out_instr_n = imem_rdata;
            pc_n        = pc + XLEN'(4);
        end else if (out_valid && if_ready) begin
            out_valid_n = 1'b0;
        end

        if (redirect_valid) begin
            capture     = 1'b0;
            out_valid_n = 1'b0;
            out_pc_n    = if_pc;
            out_instr_n = if_instr;
            pc_n        = redirect_aligned;
            case (state)
                FETCH:   state_n = (req && imem_gnt) ? DROP : FETCH;
                WAIT:    state_n = imem_rvalid ? FETCH : DROP;
                // A response landing with the redirect retires the stale request.
                DROP:    state_n = imem_rvalid ? FETCH : DROP;
                default: state_n = FETCH;
            endcase
        end
    end

    assign imem_req  = req && !rst;
    assign imem_addr = pc;
    assign if_valid  = out_valid;
    assign if_opcode = if_instr[OPCODE_W-1:0];

`ifdef FETCH_PERF_EN
    // Captured responses and FETCH cycles that did not win a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (capture) perf_fetched <= perf_fetched + 32'd1;
            if (state == FETCH && !(req && imem_gnt)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
